// File: rtl/sr04_filt_pkg.sv
// Shared types and constants for the SR04 distance filter slice.
package sr04_filt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_CONV,
        ST_DONE
    } filt_state_t;

    localparam int unsigned DIST_W       = 9;
    localparam int unsigned CONV_CYCLES  = 9;
    localparam int unsigned BCD_W        = 12;
    localparam int unsigned OUTLIER_RUN  = 3;
    localparam int unsigned DEF_DIST_MIN = 2;
    localparam int unsigned DEF_DIST_MAX = 400;

    function automatic logic in_range(input logic [DIST_W-1:0] d,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (32'(d) >= lo) && (32'(d) <= hi);
    endfunction

endpackage

// File: rtl/sr04_distance_filter_bin2bcd.sv
// Sequential 9-bit double-dabble: one add-3/shift iteration per cycle after start.
module bin2bcd_seq
    import sr04_filt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIST_W-1:0] bin,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    localparam int unsigned SH_W = BCD_W + DIST_W;

    logic [SH_W-1:0] shreg;
    logic [SH_W-1:0] dabbled;
    logic [3:0]      cnt;

    always_comb begin
        dabbled = shreg;
        for (int unsigned k = 0; k < BCD_W / 4; k++) begin
            if (dabbled[DIST_W + 4*k +: 4] >= 4'd5)
                dabbled[DIST_W + 4*k +: 4] = dabbled[DIST_W + 4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (start) begin
            shreg <= SH_W'(bin);
            cnt   <= 4'(CONV_CYCLES);
        end else if (cnt != '0) begin
            shreg <= {dabbled[SH_W-2:0], 1'b0};
            cnt   <= cnt - 4'd1;
        end
    end

    // done marks the cycle whose closing edge performs the final iteration
    assign done = (cnt == 4'd1);
    assign bcd  = shreg[SH_W-1:DIST_W];

endmodule

// File: rtl/sr04_distance_filter.sv
// Range-checked moving average of SR04 distances with BCD output.
// Optional outlier rejection is enabled by defining SR04_FILT_OUTLIER_EN.
module sr04_distance_filter
    import sr04_filt_pkg::*;
#(
    parameter int unsigned AVG_DEPTH     = 4,
    parameter int unsigned DIST_MIN      = DEF_DIST_MIN,
    parameter int unsigned DIST_MAX      = DEF_DIST_MAX,
    parameter int unsigned OUTLIER_DELTA = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] i_distance,
    input  logic              i_dist_valid,
    output logic [DIST_W-1:0] o_avg_distance,
    output logic [BCD_W-1:0]  o_bcd,
    output logic              o_valid,
    output logic              o_busy,
    output logic [7:0]        o_reject_cnt,
    output logic [7:0]        o_drop_cnt
);

    localparam int unsigned SH    = $clog2(AVG_DEPTH);
    localparam int unsigned SUM_W = DIST_W + SH;

    if (AVG_DEPTH < 2 || AVG_DEPTH > 16 || (AVG_DEPTH & (AVG_DEPTH - 1)) != 0 ||
        DIST_MIN > DIST_MAX || DIST_MAX >= 512 || OUTLIER_DELTA >= 512) begin : g_bad_cfg
        $error("sr04_distance_filter: invalid parameter set");
    end

    filt_state_t       state, state_nxt;
    logic [DIST_W-1:0] win [AVG_DEPTH];
    logic [SH-1:0]     wr_ptr;
    logic [SUM_W-1:0]  sum, sum_nxt;
    logic [DIST_W-1:0] sample_q, avg_q, avg_cur, avg_nxt;
    logic              primed, reprime_q, fill;
    logic [DIST_W-1:0] pend, cand;
    logic              pend_full;
    logic              at_check, direct, consume, store, drop;
    logic              cand_take, cand_ok, cand_reprime;
    logic              cvt_start, cvt_done;
    logic [BCD_W-1:0]  cvt_bcd;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (cvt_start),
        .bin   (avg_nxt),
        .done  (cvt_done),
        .bcd   (cvt_bcd)
    );

    // A full pending slot always has priority over a fresh pulse at check points
    assign cand      = pend_full ? pend : i_distance;
    assign cand_take = at_check && (pend_full || i_dist_valid);
    assign consume   = at_check && pend_full;
    assign direct    = at_check && !pend_full;
    assign store     = i_dist_valid && !direct;
    assign drop      = store && pend_full && !consume;
    assign avg_cur   = sum[SUM_W-1:SH];

`ifdef SR04_FILT_OUTLIER_EN
    logic [1:0]        out_run;
    logic [DIST_W-1:0] diff;
    logic              outlier;

    always_comb begin
        cand_ok      = in_range(cand, DIST_MIN, DIST_MAX);
        cand_reprime = 1'b0;
        outlier      = 1'b0;
        diff         = (cand > avg_cur) ? cand - avg_cur : avg_cur - cand;
        if (primed && cand_ok && (32'(diff) > OUTLIER_DELTA)) begin
            outlier = 1'b1;
            if (out_run >= 2'(OUTLIER_RUN))
                cand_reprime = 1'b1;
            else
                cand_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            out_run <= '0;
        else if (cand_take) begin
            if (outlier && !cand_reprime)
                out_run <= out_run + 2'd1;
            else if (cand_ok)
                out_run <= '0;
        end
    end
`else
    always_comb begin
        cand_ok      = in_range(cand, DIST_MIN, DIST_MAX);
        cand_reprime = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: state_nxt = (cand_take && cand_ok) ? ST_ACCUM : ST_IDLE;
            ST_ACCUM:         state_nxt = ST_CONV;
            ST_CONV:          if (cvt_done) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (state != ST_IDLE);
        at_check  = (state == ST_IDLE) || (state == ST_DONE);
        cvt_start = (state == ST_ACCUM);
    end

    assign fill    = !primed || reprime_q;
    assign sum_nxt = fill ? (SUM_W'(sample_q) << SH)
                          : (sum - SUM_W'(win[wr_ptr]) + SUM_W'(sample_q));
    assign avg_nxt = sum_nxt[SUM_W-1:SH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < AVG_DEPTH; i++) win[i] <= '0;
            wr_ptr    <= '0;
            sum       <= '0;
            primed    <= 1'b0;
            avg_q     <= '0;
            sample_q  <= '0;
            reprime_q <= 1'b0;
        end else begin
            if (cand_take && cand_ok) begin
                sample_q  <= cand;
                reprime_q <= cand_reprime;
            end
            if (state == ST_ACCUM) begin
                if (fill) begin
                    for (int unsigned i = 0; i < AVG_DEPTH; i++) win[i] <= sample_q;
                    wr_ptr <= '0;
                    primed <= 1'b1;
                end else begin
                    win[wr_ptr] <= sample_q;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                sum   <= sum_nxt;
                avg_q <= avg_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend         <= '0;
            pend_full    <= 1'b0;
            o_reject_cnt <= '0;
            o_drop_cnt   <= '0;
        end else begin
            if (store) begin
                pend      <= i_distance;
                pend_full <= 1'b1;
            end else if (consume) begin
                pend_full <= 1'b0;
            end
            if (cand_take && !cand_ok && o_reject_cnt != 8'hFF)
                o_reject_cnt <= o_reject_cnt + 8'd1;
            if (drop && o_drop_cnt != 8'hFF)
                o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_avg_distance <= '0;
            o_bcd          <= '0;
            o_valid        <= 1'b0;
        end else begin
            o_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                o_avg_distance <= avg_q;
                o_bcd          <= cvt_bcd;
            end
        end
    end

endmodule

// File: tb/tb_sr04_distance_filter.sv
// Directed + randomized bench for sr04_distance_filter with a queue-based average model.
`timescale 1ns/1ps
module tb_sr04_distance_filter;

    localparam int AVG_DEPTH = 4;
    localparam int DMIN      = 2;
    localparam int DMAX      = 400;
    localparam int ODELTA    = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [8:0]  i_distance = '0;
    logic        i_dist_valid = 1'b0;
    logic [8:0]  o_avg_distance;
    logic [11:0] o_bcd;
    logic        o_valid;
    logic        o_busy;
    logic [7:0]  o_reject_cnt;
    logic [7:0]  o_drop_cnt;

    always #5 clk = ~clk;

    sr04_distance_filter #(
        .AVG_DEPTH     (AVG_DEPTH),
        .DIST_MIN      (DMIN),
        .DIST_MAX      (DMAX),
        .OUTLIER_DELTA (ODELTA)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_distance     (i_distance),
        .i_dist_valid   (i_dist_valid),
        .o_avg_distance (o_avg_distance),
        .o_bcd          (o_bcd),
        .o_valid        (o_valid),
        .o_busy         (o_busy),
        .o_reject_cnt   (o_reject_cnt),
        .o_drop_cnt     (o_drop_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int hist[$];
    bit m_primed;
    int m_run, m_rej, m_drop, m_avg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int model_avg();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s / AVG_DEPTH;
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_primed = 0;
        m_run    = 0;
        m_rej    = 0;
        m_drop   = 0;
        m_avg    = 0;
    endfunction

    function automatic bit model_take(input int d);
        bit fill;
        if (d < DMIN || d > DMAX) begin
            if (m_rej < 255) m_rej++;
            return 0;
        end
        fill = !m_primed;
`ifdef SR04_FILT_OUTLIER_EN
        if (m_primed) begin
            int dev;
            dev = d - model_avg();
            if (dev < 0) dev = -dev;
            if (dev > ODELTA) begin
                if (m_run < 3) begin
                    m_run++;
                    if (m_rej < 255) m_rej++;
                    return 0;
                end
                fill = 1;
            end
            m_run = 0;
        end
`endif
        if (fill) begin
            hist.delete();
            repeat (AVG_DEPTH) hist.push_back(d);
            m_primed = 1;
        end else begin
            void'(hist.pop_front());
            hist.push_back(d);
        end
        m_avg = model_avg();
        return 1;
    endfunction

    task automatic reset_dut();
        rst          = 1'b0;
        i_dist_valid = 1'b0;
        i_distance   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic send(input int d);
        i_distance   = 9'(d);
        i_dist_valid = 1'b1;
        @(posedge clk);
        #1 i_dist_valid = 1'b0;
    endtask

    // One isolated sample: checks busy/valid timing every cycle, then the outputs.
    task automatic run_sample(input int d, input string tag);
        bit ok;
        ok = model_take(d);
        send(d);
        chk($sformatf("%s_busy0", tag), o_busy, ok);
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_busy%0d", tag, k), o_busy, ok && k <= 10);
            chk($sformatf("%s_valid%0d", tag, k), o_valid, ok && k == 11);
        end
        chk($sformatf("%s_avg", tag), o_avg_distance, m_avg);
        chk($sformatf("%s_bcd", tag), o_bcd, to_bcd(m_avg));
        chk($sformatf("%s_rej", tag), o_reject_cnt, m_rej);
    endtask

    initial begin
        int exp_avg[5];
        int smp[5];
        int d;

        reset_dut();
        chk("rst_avg", o_avg_distance, 0);
        chk("rst_bcd", o_bcd, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_rej", o_reject_cnt, 0);
        chk("rst_drop", o_drop_cnt, 0);

        run_sample(1, "rj1");
        run_sample(401, "rj401");
        run_sample(0, "rj0");
        chk("rj_cnt", o_reject_cnt, 3);
        chk("rj_avg", o_avg_distance, 0);
        chk("rj_bcd", o_bcd, 0);

        reset_dut();
        run_sample(123, "s123");
        chk("s123_lit_avg", o_avg_distance, 123);
        chk("s123_lit_bcd", o_bcd, 12'h123);

`ifndef SR04_FILT_OUTLIER_EN
        reset_dut();
        smp     = '{100, 200, 200, 200, 200};
        exp_avg = '{100, 125, 150, 175, 200};
        for (int i = 0; i < 5; i++) begin
            run_sample(smp[i], $sformatf("win%0d", i));
            chk($sformatf("win%0d_lit", i), o_avg_distance, exp_avg[i]);
        end
        chk("win_bcd200", o_bcd, 12'h200);
`endif

        reset_dut();
        run_sample(400, "max");
        chk("max_bcd", o_bcd, 12'h400);
        reset_dut();
        run_sample(2, "min");
        chk("min_avg", o_avg_distance, 2);

        // back-to-back: 60 lands in the pending slot and is overwritten by 70
        reset_dut();
        void'(model_take(50));
        m_drop++;
        void'(model_take(70));
        i_distance = 9'd50; i_dist_valid = 1'b1;
        @(posedge clk); #1 i_distance = 9'd60;
        @(posedge clk); #1 i_distance = 9'd70;
        @(posedge clk); #1 i_dist_valid = 1'b0;
        for (int k = 3; k <= 24; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b_valid%0d", k), o_valid, k == 11 || k == 22);
            if (k == 11) chk("b2b_first_avg", o_avg_distance, 50);
        end
        chk("b2b_avg", o_avg_distance, 55);
        chk("b2b_model_avg", o_avg_distance, m_avg);
        chk("b2b_drop", o_drop_cnt, 1);

`ifdef SR04_FILT_OUTLIER_EN
        reset_dut();
        run_sample(100, "ol_prime");
        for (int i = 0; i < 3; i++) run_sample(300, $sformatf("ol_rj%0d", i));
        chk("ol_rej3", o_reject_cnt, 3);
        chk("ol_hold", o_avg_distance, 100);
        run_sample(300, "ol_step");
        chk("ol_step_avg", o_avg_distance, 300);
`endif

        for (int i = 0; i < 30; i++) begin
            d = int'($urandom_range(0, 450));
            run_sample(d, $sformatf("rnd%0d", i));
        end
        chk("rnd_drop", o_drop_cnt, m_drop);

        // reset five edges into a conversion abandons it
        reset_dut();
        run_sample(500, "pre_rj");
        run_sample(250, "pre");
        send(90);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", o_busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_avg", o_avg_distance, 0);
        chk("mid_bcd", o_bcd, 0);
        chk("mid_valid", o_valid, 0);
        chk("mid_busy_rst", o_busy, 0);
        chk("mid_rej", o_reject_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mid_novalid%0d", k), o_valid, 0);
        end
        run_sample(80, "reprime");
        chk("reprime_lit", o_avg_distance, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sr04_distance_filter.md
Name: sr04_distance_filter

Overview:
- Sits between controller_SR04 and the FND source mux in the system top level.
- Takes each raw 9-bit distance (cm) produced by the ultrasonic controller and rejects out-of-range samples.
- Keeps a moving average over a power-of-two window, then converts the average to 3-digit BCD with a sequential double-dabble.
- Gives the FND path a stable, debounced reading instead of a per-cycle divide/modulo.

Parameters:
- AVG_DEPTH, 4, window length in samples; must be a power of two, 2..16.
- DIST_MIN, 2, smallest accepted distance in cm.
- DIST_MAX, 400, largest accepted distance in cm.
- OUTLIER_DELTA, 50, maximum |sample − current average| in cm; used only with the optional feature.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous active-low reset; the block is in reset while rst==0.
- i_distance  input  9  raw distance in cm from controller_SR04.
- i_dist_valid  input  1  one-cycle pulse: i_distance is a new measurement.
- o_avg_distance  output  9  filtered binary distance in cm.
- o_bcd  output  12  {hundreds, tens, ones}, 4 bits each.
- o_valid  output  1  one-cycle pulse: o_avg_distance and o_bcd just updated.
- o_busy  output  1  high while a sample is being processed (any state except IDLE).
- o_reject_cnt  output  8  saturating count of rejected samples.
- o_drop_cnt  output  8  saturating count of samples overwritten in the pending slot.

Behaviour:
- Reset (rst==0, asynchronous):
  - All outputs are 0.
  - Window entries, running sum, pending slot and the "primed" flag are cleared.
  - FSM returns to IDLE.
  - Reset mid-conversion abandons the conversion; o_valid does not fire.
- FSM states: IDLE, ACCUM, CONV, DONE.
- IDLE:
  - On i_dist_valid, range-check the sample: accept if DIST_MIN ≤ i_distance ≤ DIST_MAX.
  - Out-of-range: increment o_reject_cnt (saturates at 255); stay in IDLE; outputs unchanged.
  - In range: latch the sample and go to ACCUM.
- ACCUM (1 cycle):
  - If not primed: write the sample to all AVG_DEPTH slots, set sum = sample × AVG_DEPTH, set primed.
  - Otherwise: replace the oldest slot (circular write pointer wraps at AVG_DEPTH−1) and set sum = sum − oldest + sample.
  - Sum width is 9 + log2(AVG_DEPTH).
  - avg = sum >> log2(AVG_DEPTH), truncating; loaded into the converter. Go to CONV.
- CONV (exactly 9 cycles):
  - Double-dabble over 9 bits: add 3 to any nibble ≥ 5, then shift left 1 per cycle.
  - Go to DONE after the 9th iteration.
- DONE (1 cycle):
  - Register o_avg_distance and o_bcd; pulse o_valid.
  - If the pending slot is full, consume it (same range check as IDLE, including reject counting), then go to ACCUM on accept or IDLE on reject.
  - If the pending slot is empty, go to IDLE.
- Latency:
  - Sample accepted at rising edge E.
  - o_avg_distance, o_bcd and o_valid all update at edge E+11.
  - o_valid is high for exactly one cycle.
- Pending slot:
  - i_dist_valid while o_busy stores the sample in a single-entry pending slot.
  - If the slot is already full, it is overwritten (latest wins) and o_drop_cnt increments (saturates at 255).
- Simultaneous events:
  - i_dist_valid in the same cycle DONE consumes the slot: the new sample fills the freed slot, with no drop.
- Outputs hold their last value between updates.
- o_bcd digits are always 0..9; the maximum value is 400 → 12'h400.

Optional Feature:
- Macro: SR04_FILT_OUTLIER_EN.
- When defined (applies to primed samples only):
  - A range-valid sample with |sample − avg| > OUTLIER_DELTA is rejected and counted in o_reject_cnt.
  - After 3 consecutive outlier rejections, the 4th outlier is accepted and re-primes the window, filling all slots, so genuine step changes are followed.
  - Any non-outlier resets the consecutive counter.
- When undefined: only the DIST_MIN/DIST_MAX check is applied; no outlier logic or consecutive counter is synthesized.

Decomposition:
- Package sr04_filt_pkg holds:
  - FSM state encoding (IDLE/ACCUM/CONV/DONE).
  - CONV_CYCLES = 9, BCD_W = 12, OUTLIER_RUN = 3.
  - Default DIST_MIN/DIST_MAX.
- Sub-module bin2bcd_seq (9-bit sequential double-dabble) has a start/done handshake and is instantiated once.
- Window RAM, sum and the FSM stay in the top module.

Test Plan:
- Reset then single sample 123 → o_valid at E+11; o_avg_distance=123, o_bcd=12'h123; o_busy high for edges E..E+10.
- AVG_DEPTH=4; samples 100, 200, 200, 200, 200 (spaced ≥12 cycles) → averages 100, 125, 150, 175, 200; BCD 100, 125, 150, 175, 200.
- Samples 1, 401, 0 → no o_valid; o_reject_cnt=3; outputs stay at reset 0.
- Samples 50, 60, 70 issued on consecutive cycles → 60 dropped (o_drop_cnt=1); 70 processed after 50; second o_valid at E+22 with avg (50·3+70)/4=55.
- Assert rst low at cycle E+5 of a conversion → all outputs 0 immediately; no o_valid; next sample 80 re-primes → 80.
- With SR04_FILT_OUTLIER_EN:
  - Primed at 100; samples 300 ×3 → o_reject_cnt=3, avg stays 100.
  - 4th sample 300 → avg=300.
